// File: rtl/run_match_detector.sv
// run_match_detector
//
// Streaming consumer that compares every accepted input word against a
// programmed pattern and reports a hit once a run of consecutive matching
// words reaches a programmed threshold. Runs are non-overlapping: after a
// hit is handshaken, the search restarts from an empty run. Detection
// continues until abort.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   cfg_load         latch cfg_pattern / cfg_thresh (and cfg_mask); IDLE only
//   cfg_pattern      pattern to match
//   cfg_mask         per-bit compare enable (only with RUN_MATCH_MASK_EN)
//   cfg_thresh       required consecutive matches; 0 is treated as 1
//   arm              start searching; IDLE only
//   abort            return to IDLE from any state, dropping a pending hit
//   in_valid/in_data/in_ready   input word stream (valid/ready)
//   hit_valid/hit_ready         hit report handshake
//   hit_index        sample index of the word that completed the run
//   hit_len          reported run length (the effective threshold)
//   hit_count        hits handshaken since arm, saturating
//   busy             state is not IDLE
//
// Optional feature:
//   RUN_MATCH_MASK_EN  adds cfg_mask; bits with mask 0 are don't-care.
//                      Without it every bit is compared (mask all ones).

module eq_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq
);
  assign eq = (a == b);
endmodule

module run_match_detector #(
  parameter int N  = 4,
  parameter int TW = 4,
  parameter int IW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_load,
  input  logic [N-1:0]  cfg_pattern,
`ifdef RUN_MATCH_MASK_EN
  input  logic [N-1:0]  cfg_mask,
`endif
  input  logic [TW-1:0] cfg_thresh,
  input  logic          arm,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  output logic          hit_valid,
  input  logic          hit_ready,
  output logic [IW-1:0] hit_index,
  output logic [TW-1:0] hit_len,
  output logic [CW-1:0] hit_count,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, SEARCH, RUN, REPORT} state_t;

  state_t        state;
  logic [N-1:0]  pattern;
  logic [TW-1:0] thresh;
  logic [TW-1:0] run;
  logic [IW-1:0] idx;

  logic          accept;
  logic          match;
  logic [TW-1:0] run_next;
  logic [N-1:0]  cmp_a;
  logic [N-1:0]  cmp_b;

`ifdef RUN_MATCH_MASK_EN
  logic [N-1:0]  mask;

  // Masking both operands turns don't-care bits into equal zeros.
  assign cmp_a = in_data & mask;
  assign cmp_b = pattern & mask;
`else
  assign cmp_a = in_data;
  assign cmp_b = pattern;
`endif

  eq_n #(.N(N)) u_eq (
    .a  (cmp_a),
    .b  (cmp_b),
    .eq (match)
  );

  assign in_ready = (state == SEARCH) || (state == RUN);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;

  // run stays strictly below thresh outside REPORT, so run+1 never wraps
  // even when thresh is the all-ones maximum.
  assign run_next = run + TW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pattern   <= '0;
      thresh    <= TW'(1);
      run       <= '0;
      idx       <= '0;
      hit_valid <= 1'b0;
      hit_index <= '0;
      hit_len   <= '0;
      hit_count <= '0;
`ifdef RUN_MATCH_MASK_EN
      mask      <= '1;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Config is written before the arm decision so that a load in
          // the same cycle as arm governs that search.
          if (cfg_load) begin
            pattern <= cfg_pattern;
            thresh  <= (cfg_thresh == '0) ? TW'(1) : cfg_thresh;
`ifdef RUN_MATCH_MASK_EN
            mask    <= cfg_mask;
`endif
          end
          if (arm && !abort) begin
            state     <= SEARCH;
            idx       <= '0;
            run       <= '0;
            hit_count <= '0;
          end
        end

        SEARCH: begin
          if (abort) begin
            state <= IDLE;
            run   <= '0;
          end else if (accept) begin
            idx <= idx + 1'b1;
            if (match) begin
              run <= TW'(1);
              if (thresh == TW'(1)) begin
                state     <= REPORT;
                hit_valid <= 1'b1;
                hit_index <= idx;
                hit_len   <= thresh;
              end else begin
                state <= RUN;
              end
            end
          end
        end

        RUN: begin
          if (abort) begin
            state <= IDLE;
            run   <= '0;
          end else if (accept) begin
            idx <= idx + 1'b1;
            if (match) begin
              run <= run_next;
              if (run_next == thresh) begin
                state     <= REPORT;
                hit_valid <= 1'b1;
                hit_index <= idx;
                hit_len   <= thresh;
              end
            end else begin
              // The breaking word is discarded rather than seeding a new run.
              run   <= '0;
              state <= SEARCH;
            end
          end
        end

        REPORT: begin
          if (abort) begin
            state     <= IDLE;
            hit_valid <= 1'b0;
            run       <= '0;
          end else if (hit_ready) begin
            state     <= SEARCH;
            hit_valid <= 1'b0;
            run       <= '0;
            if (hit_count != '1) begin
              hit_count <= hit_count + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
